// File: rtl/smc_loop_sequencer.sv
// Sample-rate sequencer for the smc_simple core: period tick, operand capture with
// backward-difference velocity, settle window, output clamp and valid/ready delivery.
module smc_loop_sequencer #(
  parameter int                 PERIOD = 1000,
  parameter int                 SETTLE = 4,
  parameter logic signed [31:0] U_MAX  = 32'sd2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic signed [31:0] thetad,
  input  logic signed [31:0] dthetad,
  input  logic signed [31:0] ddthetad,
  input  logic signed [31:0] theta_in,
  output logic signed [31:0] smc_thetad,
  output logic signed [31:0] smc_dthetad,
  output logic signed [31:0] smc_ddthetad,
  output logic signed [31:0] smc_theta,
  output logic signed [31:0] smc_dtheta,
  input  logic signed [31:0] smc_u,
  output logic signed [31:0] u_out,
  output logic               u_valid,
  input  logic               u_ready,
  output logic               sat_flag,
  output logic [15:0]        overrun_cnt
);

  localparam int CW = $clog2(PERIOD + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic signed [32:0] D_MAX = 33'sd2147483647;
  localparam logic signed [32:0] D_MIN = -33'sd2147483647;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CAPTURE, S_SETTLE, S_EVAL} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt;
  logic [SW-1:0]         settle_cnt;
  logic signed [31:0]    theta_prev;
  logic                  first_sample;
  logic                  tick, drop, eval_over;
  logic signed [32:0]    diff;
  logic [16:0]           ovr_sum;
  logic [15:0]           ovr_n;

  // Symmetric saturation of the 33-bit difference; -2^31 is never produced.
  function automatic logic signed [31:0] sat32(input logic signed [32:0] d);
    if (d > D_MAX)      return D_MAX[31:0];
    else if (d < D_MIN) return D_MIN[31:0];
    else                return d[31:0];
  endfunction

  function automatic logic clamp_hit(input logic signed [31:0] v);
    return (v > U_MAX) || (v < -U_MAX);
  endfunction

  function automatic logic signed [31:0] clamp_u(input logic signed [31:0] v);
    if (v > U_MAX)       return U_MAX;
    else if (v < -U_MAX) return -U_MAX;
    else                 return v;
  endfunction

  assign tick      = enable && (cnt == CW'(PERIOD - 1));
  assign drop      = tick && (state != S_WAIT);
  assign eval_over = enable && (state == S_EVAL) && u_valid && !u_ready;
  assign diff      = $signed({theta_in[31], theta_in}) - $signed({theta_prev[31], theta_prev});
  assign ovr_sum   = {1'b0, overrun_cnt} + 17'(drop) + 17'(eval_over);
  assign ovr_n     = ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (enable) state_n = S_WAIT;
      S_WAIT:    if (tick) state_n = S_CAPTURE;
      S_CAPTURE: state_n = S_SETTLE;
      S_SETTLE:  if (settle_cnt == SW'(SETTLE - 1)) state_n = S_EVAL;
      S_EVAL:    state_n = S_WAIT;
      default:   state_n = S_IDLE;
    endcase
    if (!enable) state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      overrun_cnt <= '0;
    end else begin
      state       <= state_n;
      overrun_cnt <= ovr_n;
      if (!enable || tick) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
    end
  end

  // Capture stage: operands and velocity estimate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smc_thetad   <= '0;
      smc_dthetad  <= '0;
      smc_ddthetad <= '0;
      smc_theta    <= '0;
      smc_dtheta   <= '0;
      theta_prev   <= '0;
      first_sample <= 1'b1;
      settle_cnt   <= '0;
    end else if (!enable) begin
      first_sample <= 1'b1;
      settle_cnt   <= '0;
    end else if (state == S_CAPTURE) begin
      smc_thetad   <= thetad;
      smc_dthetad  <= dthetad;
      smc_ddthetad <= ddthetad;
      smc_theta    <= theta_in;
      smc_dtheta   <= first_sample ? 32'sd0 : sat32(diff);
      theta_prev   <= theta_in;
      first_sample <= 1'b0;
      settle_cnt   <= '0;
    end else if (state == S_SETTLE) begin
      settle_cnt   <= settle_cnt + 1'b1;
    end
  end

  // Output stage: clamp and handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_out    <= '0;
      u_valid  <= 1'b0;
      sat_flag <= 1'b0;
    end else if (!enable) begin
      u_out    <= '0;
      u_valid  <= 1'b0;
      sat_flag <= 1'b0;
    end else if (state == S_EVAL) begin
      u_out    <= clamp_u(smc_u);
      sat_flag <= clamp_hit(smc_u);
      u_valid  <= 1'b1;
    end else if (u_valid && u_ready) begin
      u_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_smc_loop_sequencer.sv
// Directed bench for smc_loop_sequencer: latency, backward difference, clamp,
// back-pressure overruns, enable/reset aborts, and a too-short-period stress instance.
module tb_smc_loop_sequencer;

  logic clk, rst;
  logic enable, u_ready;
  logic signed [31:0] thetad, dthetad, ddthetad, theta_in;
  logic signed [31:0] smc_thetad, smc_dthetad, smc_ddthetad, smc_theta, smc_dtheta;
  logic signed [31:0] smc_u, u_out;
  logic u_valid, sat_flag;
  logic [15:0] overrun_cnt;

  logic use_force;
  logic signed [31:0] u_force;

  logic enable2, u_ready2;
  logic signed [31:0] s_thetad, s_dthetad, s_ddthetad, s_theta, s_dtheta;
  logic signed [31:0] smc_u2, u_out2;
  logic u_valid2, sat_flag2;
  logic [15:0] overrun2;

  int checks = 0;
  int errors = 0;
  int vcount;

  always #5 clk = ~clk;

  // Stand-in core: a simple combinational function of the operands, or a forced value
  always_comb begin
    smc_u = smc_thetad - smc_theta;
    if (use_force) smc_u = u_force;
  end
  assign smc_u2 = 32'sd7;

  smc_loop_sequencer #(.PERIOD(20), .SETTLE(4), .U_MAX(32'sd2000000)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .thetad(thetad), .dthetad(dthetad), .ddthetad(ddthetad), .theta_in(theta_in),
    .smc_thetad(smc_thetad), .smc_dthetad(smc_dthetad), .smc_ddthetad(smc_ddthetad),
    .smc_theta(smc_theta), .smc_dtheta(smc_dtheta), .smc_u(smc_u),
    .u_out(u_out), .u_valid(u_valid), .u_ready(u_ready),
    .sat_flag(sat_flag), .overrun_cnt(overrun_cnt)
  );

  smc_loop_sequencer #(.PERIOD(4), .SETTLE(4), .U_MAX(32'sd2000000)) dut_stress (
    .clk(clk), .rst(rst), .enable(enable2),
    .thetad(thetad), .dthetad(dthetad), .ddthetad(ddthetad), .theta_in(theta_in),
    .smc_thetad(s_thetad), .smc_dthetad(s_dthetad), .smc_ddthetad(s_ddthetad),
    .smc_theta(s_theta), .smc_dtheta(s_dtheta), .smc_u(smc_u2),
    .u_out(u_out2), .u_valid(u_valid2), .u_ready(u_ready2),
    .sat_flag(sat_flag2), .overrun_cnt(overrun2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!u_valid && n < budget);
    check("valid_seen", {31'b0, u_valid}, 32'd1);
  endtask

  initial begin
    clk = 0; rst = 1; enable = 0; enable2 = 0;
    u_ready = 1; u_ready2 = 1; use_force = 0; u_force = 0;
    thetad = 0; dthetad = 0; ddthetad = 0; theta_in = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    check("rst_u_out", u_out, 32'd0);
    check("rst_u_valid", {31'b0, u_valid}, 32'd0);
    check("rst_sat", {31'b0, sat_flag}, 32'd0);
    check("rst_overrun", {16'b0, overrun_cnt}, 32'd0);
    check("rst_dtheta", smc_dtheta, 32'd0);

    // Enable in cycle 0: tick at 19, result at 26
    step();
    enable = 1; thetad = 11; dthetad = 22; ddthetad = 33; theta_in = 100;
    repeat (25) step();
    check("lat_pre", {31'b0, u_valid}, 32'd0);
    step();
    check("lat_valid", {31'b0, u_valid}, 32'd1);
    check("first_u", u_out, -32'sd89);
    check("first_dtheta", smc_dtheta, 32'd0);
    check("first_theta", smc_theta, 32'd100);
    check("first_ddthetad", smc_ddthetad, 32'd33);
    check("first_sat", {31'b0, sat_flag}, 32'd0);
    step();
    check("hs_clear", {31'b0, u_valid}, 32'd0);

    theta_in = 130;
    wait_valid(40);
    check("diff_30", smc_dtheta, 32'd30);
    check("diff_u", u_out, -32'sd119);

    theta_in = 32'sh7FFFFFFF; use_force = 1; u_force = 1234;
    wait_valid(40);
    check("diff_big", smc_dtheta, 32'sd2147483517);
    check("u_1234", u_out, 32'sd1234);
    check("sat_1234", {31'b0, sat_flag}, 32'd0);

    theta_in = 32'sh80000000; u_force = 5000000;
    wait_valid(40);
    check("diff_sat", smc_dtheta, -32'sd2147483647);
    check("u_pos_clamp", u_out, 32'sd2000000);
    check("sat_pos", {31'b0, sat_flag}, 32'd1);

    u_force = -5000000;
    wait_valid(40);
    check("u_neg_clamp", u_out, -32'sd2000000);
    check("sat_neg", {31'b0, sat_flag}, 32'd1);
    check("ovr_none", {16'b0, overrun_cnt}, 32'd0);

    u_force = 2000000;
    wait_valid(40);
    check("u_edge", u_out, 32'sd2000000);
    check("sat_edge", {31'b0, sat_flag}, 32'd0);

    // Back-pressure across three evaluations
    step();
    u_ready = 0; u_force = 100;
    wait_valid(40);
    check("bp_u1", u_out, 32'd100);
    check("bp_ovr0", {16'b0, overrun_cnt}, 32'd0);
    u_force = 200;
    repeat (19) step();
    check("bp_hold_valid", {31'b0, u_valid}, 32'd1);
    check("bp_hold_u", u_out, 32'd100);
    step();
    check("bp_u2", u_out, 32'd200);
    check("bp_ovr1", {16'b0, overrun_cnt}, 32'd1);
    u_force = 300;
    repeat (20) step();
    check("bp_u3", u_out, 32'd300);
    check("bp_valid3", {31'b0, u_valid}, 32'd1);
    check("bp_ovr2", {16'b0, overrun_cnt}, 32'd2);
    u_ready = 1;
    step();
    check("bp_release", {31'b0, u_valid}, 32'd0);
    check("bp_ovr_keep", {16'b0, overrun_cnt}, 32'd2);

    // Drop enable in the middle of SETTLE
    u_ready = 0; u_force = 5000000;
    wait_valid(40);
    repeat (16) step();
    check("en_pre_valid", {31'b0, u_valid}, 32'd1);
    enable = 0;
    step();
    check("en_u_out", u_out, 32'd0);
    check("en_u_valid", {31'b0, u_valid}, 32'd0);
    check("en_sat", {31'b0, sat_flag}, 32'd0);
    check("en_ovr_kept", {16'b0, overrun_cnt}, 32'd2);

    enable = 1; u_ready = 1; use_force = 0; theta_in = 500;
    wait_valid(40);
    check("reen_dtheta", smc_dtheta, 32'd0);
    check("reen_theta", smc_theta, 32'd500);
    check("reen_u", u_out, -32'sd489);

    // Reset pulse during EVAL
    theta_in = 777;
    repeat (19) step();
    rst = 1;
    #1;
    check("rst_eval_u", u_out, 32'd0);
    check("rst_eval_valid", {31'b0, u_valid}, 32'd0);
    check("rst_eval_ovr", {16'b0, overrun_cnt}, 32'd0);
    check("rst_eval_theta", smc_theta, 32'd0);
    step();
    check("rst_eval_next", {31'b0, u_valid}, 32'd0);
    rst = 0;
    wait_valid(40);
    check("post_rst_dtheta", smc_dtheta, 32'd0);
    check("post_rst_theta", smc_theta, 32'd777);

    // Period shorter than one evaluation: every other tick is dropped
    vcount = 0;
    enable2 = 1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (u_valid2) vcount++;
      if (k == 8) check("stress_ovr_first", {16'b0, overrun2}, 32'd1);
    end
    check("stress_ovr", {16'b0, overrun2}, 32'd5);
    check("stress_results", vcount, 32'd4);
    check("stress_u", u_out2, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
